// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding one UART transmitter, one frame per grant
// Ports:
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   req, req_data    per-requester request level and packed characters (requester i at [i*D +: D])
//   grant, done      one-hot 1-cycle pulses: byte captured / frame finished
//   err              1-cycle pulse on WAIT timeout abort
//   busy, owner      not-idle flag, current or last granted requester
//   tx_start, tx_data, tx_done  transmitter handshake
module uart_tx_arbiter #(
    parameter int D       = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 200000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*D-1:0]         req_data,
    output logic [NREQ-1:0]           grant,
    output logic [NREQ-1:0]           done,
    output logic                      err,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      tx_start,
    output logic [D-1:0]              tx_data,
    input  logic                      tx_done
);
    localparam int OW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]    state;
    logic [OW-1:0] ptr;
    logic [OW-1:0] win;
    logic [TW-1:0] timer;
    logic          tx_prev;
    logic          rise;
    int            idx;
    logic          found;

    // only a fresh 0->1 transition counts, so a level left high from before START is ignored
    assign rise = tx_done & ~tx_prev;

    // first requester at or after ptr+1, wrapping
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                win   = OW'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= OW'(NREQ - 1);
            timer    <= '0;
            tx_prev  <= 1'b0;
            grant    <= '0;
            done     <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            owner    <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            grant    <= '0;
            done     <= '0;
            err      <= 1'b0;
            tx_start <= 1'b0;
            tx_prev  <= tx_done;
            case (state)
                IDLE: if (found) begin
                    tx_data  <= req_data[int'(win)*D +: D];
                    owner    <= win;
                    ptr      <= win;
                    grant    <= NREQ'(1) << win;
                    tx_start <= 1'b1;
                    busy     <= 1'b1;
                    state    <= START;
                end
                START: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: if (rise) begin
                    done  <= NREQ'(1) << owner;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end else begin
                    timer <= timer + TW'(1);
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
